// File: rtl/genome_pack_stream.sv
// Packs an ASCII nucleotide stream into 2-bit codes, LP_BASES per output word, base 0 at the LSBs.
// Word valid one cycle after its final base is accepted; input stalls while an output word waits unaccepted.
module genome_pack_stream #(
  parameter int C_M_AXI_DATA_WIDTH = 512
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [7:0]                    s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [31:0]                   base_count,
  output logic                          bad_char
);

  localparam int LP_BASES = C_M_AXI_DATA_WIDTH / 2;
  localparam int IDX_W    = $clog2(LP_BASES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                        state;
  logic [C_M_AXI_DATA_WIDTH-1:0] acc;
  logic [C_M_AXI_DATA_WIDTH-1:0] acc_next;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W:0]                shamt;
  logic [1:0]                    code;
  logic                          bad;
  logic                          accept;
  logic                          word_end;

  always_comb begin
    code = 2'b00;
    bad  = 1'b0;
    case (s_axis_tdata)
      8'h41, 8'h61: code = 2'b00;
      8'h43, 8'h63: code = 2'b01;
      8'h47, 8'h67: code = 2'b10;
      8'h54, 8'h74: code = 2'b11;
      default:      bad  = 1'b1;
    endcase
  end

  assign s_axis_tready = (state == S_RUN) && (!m_axis_tvalid || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign word_end      = accept && ((idx == IDX_W'(LP_BASES - 1)) || s_axis_tlast);
  assign shamt         = {idx, 1'b0};
  // Slots above idx are always zero, so OR-ing in the new code is enough.
  assign acc_next      = acc | (C_M_AXI_DATA_WIDTH'(code) << shamt);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      acc           <= '0;
      idx           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      ap_done       <= 1'b0;
      base_count    <= '0;
      bad_char      <= 1'b0;
    end else begin
      ap_done <= 1'b0;
      if (m_axis_tvalid && m_axis_tready)
        m_axis_tvalid <= 1'b0;
      // A load in the same cycle as a drain overrides the clear above.
      if (word_end) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= acc_next;
        m_axis_tlast  <= s_axis_tlast;
      end
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            base_count <= '0;
            bad_char   <= 1'b0;
            acc        <= '0;
            idx        <= '0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            base_count <= base_count + 32'd1;
            if (bad)
              bad_char <= 1'b1;
            if (word_end) begin
              acc <= '0;
              idx <= '0;
            end else begin
              acc <= acc_next;
              idx <= idx + 1'b1;
            end
            if (s_axis_tlast)
              state <= S_DONE;
          end
        end
        S_DONE: begin
          if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            ap_done <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_genome_pack_stream.sv
// Directed bench for genome_pack_stream; expected words are queued when their last base is driven.
module tb_genome_pack_stream;

  localparam int W = 512;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } exp_t;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         ap_start;
  logic         ap_done;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [7:0]   s_axis_tdata;
  logic         s_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tlast;
  logic [31:0]  base_count;
  logic         bad_char;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  genome_pack_stream #(.C_M_AXI_DATA_WIDTH(W)) dut (
    .aclk(aclk), .aresetn(aresetn), .ap_start(ap_start), .ap_done(ap_done),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .base_count(base_count), .bad_char(bad_char)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output handshakes are seen at the negedge before the edge that completes them.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      chk("word_expected", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_data", m_axis_tdata, e.data);
        chk("word_last", W'(m_axis_tlast), W'(e.last));
      end
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic pulse_start();
    ap_start = 1'b1;
    @(posedge aclk); #1;
    ap_start = 1'b0;
  endtask

  task automatic send_base(input logic [7:0] c, input logic last);
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = c;
    s_axis_tlast  = last;
    @(negedge aclk);
    while (!s_axis_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axis_tready) chk("send_timeout", W'(s_axis_tready), W'(1));
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge aclk);
    while (!ap_done && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("done_seen", W'(ap_done), W'(1));
    @(negedge aclk);
    chk("done_one_cycle", W'(ap_done), W'(0));
    @(posedge aclk); #1;
  endtask

  initial begin
    exp_t        e;
    logic [W-1:0] v;
    aresetn = 1'b0; ap_start = 1'b0; s_axis_tvalid = 1'b0;
    s_axis_tdata = 8'h00; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tready", W'(s_axis_tready), W'(0));
    chk("rst_tvalid", W'(m_axis_tvalid), W'(0));
    chk("rst_tdata", m_axis_tdata, W'(0));
    chk("rst_count", W'(base_count), W'(0));
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("idle_tready", W'(s_axis_tready), W'(0));

    // Full word of ACGT: each byte packs to 0xE4.
    pulse_start();
    for (int i = 0; i < W; i += 8) v[i +: 8] = 8'hE4;
    e.last = 1'b1; e.data = v;
    exp_q.push_back(e);
    for (int i = 0; i < 256; i++)
      send_base((i % 4 == 0) ? "A" : (i % 4 == 1) ? "C" : (i % 4 == 2) ? "G" : "T", i == 255);
    wait_done();
    chk("acgt_count", W'(base_count), W'(256));
    chk("acgt_bad", W'(bad_char), W'(0));

    // Short final word with clean upper bits and one-cycle latency.
    pulse_start();
    e.last = 1'b1; e.data = W'(8'h3A);
    exp_q.push_back(e);
    send_base("G", 1'b0);
    send_base("G", 1'b0);
    chk("ggt_no_early_valid", W'(m_axis_tvalid), W'(0));
    send_base("T", 1'b1);
    chk("ggt_latency", W'(m_axis_tvalid), W'(1));
    wait_done();
    chk("ggt_count", W'(base_count), W'(3));

    // Two all-ones words with the first stalled downstream.
    pulse_start();
    e.last = 1'b0; e.data = '1;
    exp_q.push_back(e);
    e.last = 1'b1;
    exp_q.push_back(e);
    for (int i = 0; i < 255; i++) send_base("T", 1'b0);
    m_axis_tready = 1'b0;
    send_base("T", 1'b0);
    s_axis_tvalid = 1'b1; s_axis_tdata = "T";
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("stall_tready", W'(s_axis_tready), W'(0));
      chk("stall_tvalid", W'(m_axis_tvalid), W'(1));
    end
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 256; i++) send_base("T", i == 255);
    wait_done();
    chk("stall_count", W'(base_count), W'(512));

    // Invalid character encodes as 00 and raises a sticky flag.
    pulse_start();
    e.last = 1'b1; e.data = W'(8'h10);
    exp_q.push_back(e);
    send_base("a", 1'b0);
    send_base("N", 1'b0);
    send_base("c", 1'b1);
    wait_done();
    repeat (3) @(posedge aclk);
    #1;
    chk("bad_held", W'(bad_char), W'(1));
    pulse_start();
    chk("bad_cleared", W'(bad_char), W'(0));
    chk("count_cleared", W'(base_count), W'(0));

    // Reset mid-sequence discards the partial word.
    for (int i = 0; i < 100; i++) send_base("A", 1'b0);
    chk("pre_rst_count", W'(base_count), W'(100));
    aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", W'(m_axis_tvalid), W'(0));
    chk("mid_rst_tready", W'(s_axis_tready), W'(0));
    chk("mid_rst_count", W'(base_count), W'(0));
    chk("mid_rst_done", W'(ap_done), W'(0));
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("post_rst_tvalid", W'(m_axis_tvalid), W'(0));
    chk("post_rst_tready", W'(s_axis_tready), W'(0));
    pulse_start();
    e.last = 1'b1; e.data = W'(8'h55);
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) send_base("C", i == 3);
    wait_done();
    chk("cccc_count", W'(base_count), W'(4));

    // ap_start while running is ignored.
    pulse_start();
    for (int i = 0; i < 10; i++) send_base("G", 1'b0);
    pulse_start();
    send_base("G", 1'b0);
    chk("restart_ignored", W'(base_count), W'(11));
    e.last = 1'b1; e.data = W'(40'hAA_AAAA_AAAA);
    exp_q.push_back(e);
    for (int i = 11; i < 20; i++) send_base("G", i == 19);
    wait_done();
    chk("restart_count", W'(base_count), W'(20));
    chk("queue_drained", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/genome_pack_stream.md
GENOME_PACK_STREAM -- requirements
Module: genome_pack_stream

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 512, giving the output word width in bits; it SHALL be even and at least 16.
REQ-002 SHALL have derived constant LP_BASES = C_M_AXI_DATA_WIDTH/2, the number of bases per output word.
REQ-003 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
- aclk  in  1  sole clock
- aresetn  in  1  asynchronous active-low reset
- ap_start  in  1  single-cycle start pulse
- ap_done  out  1  single-cycle completion pulse
- s_axis_tvalid  in  1  input base valid
- s_axis_tready  out  1  input base accepted
- s_axis_tdata  in  8  ASCII nucleotide character
- s_axis_tlast  in  1  last base of sequence
- m_axis_tvalid  out  1  packed word valid (feeds the genome write stage's tvalid)
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  C_M_AXI_DATA_WIDTH  packed 2-bit bases
- m_axis_tlast  out  1  final word of sequence
- base_count  out  32  bases accepted since the last ap_start
- bad_char  out  1  sticky flag for an invalid character

Function
REQ-004 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-005 IDLE: s_axis_tready=0; ap_start=1 SHALL clear base_count, bad_char, the accumulator, and index idx, and SHALL move to RUN on the next edge.
REQ-006 ap_start in RUN or DONE SHALL be ignored.
REQ-007 Encoding SHALL be A/a=00, C/c=01, G/g=10, T/t=11; any other byte SHALL encode as 00 and set bad_char=1.
REQ-008 A beat SHALL be accepted only in RUN when s_axis_tvalid && s_axis_tready.
REQ-009 Each accepted base SHALL write its code into accumulator bits [2*idx+1:2*idx] (base 0 at the LSBs) and SHALL increment base_count, wrapping modulo 2^32.
REQ-010 s_axis_tready SHALL equal (state==RUN) && (!m_axis_tvalid || m_axis_tready); the block SHALL never drop a beat.
REQ-011 When an accepted beat has idx==LP_BASES-1 or s_axis_tlast=1:
- the accumulator, including this base, SHALL load the output register and set m_axis_tvalid on the next edge;
- m_axis_tlast SHALL load from s_axis_tlast;
- the accumulator and idx SHALL clear to 0;
- unused upper bits of a partial word SHALL be 0.
REQ-012 Otherwise an accepted beat SHALL increment idx.
REQ-013 Latency SHALL be one cycle from acceptance of a word's final base to m_axis_tvalid=1.
REQ-014 m_axis_tvalid, m_axis_tdata, and m_axis_tlast SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-015 On an output handshake, m_axis_tvalid SHALL clear unless a new word loads in the same cycle; simultaneous drain and load SHALL keep m_axis_tvalid=1 with the new data.
REQ-016 A beat with s_axis_tlast=1 SHALL move the FSM to DONE. DONE SHALL accept no input.
REQ-017 In DONE, the cycle on which the tlast word handshakes SHALL produce ap_done=1 for exactly one cycle on the following cycle, and the FSM SHALL return to IDLE.
REQ-018 No output word SHALL ever be empty; tlast with idx==0 SHALL produce a 1-base word.
REQ-019 base_count and bad_char SHALL hold their values through DONE and IDLE until the next ap_start.

Reset
REQ-020 aresetn=0 SHALL asynchronously set:
- FSM=IDLE;
- s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0;
- ap_done=0, base_count=0, bad_char=0;
- idx=0 and accumulator=0.
REQ-021 Reset mid-sequence SHALL discard partial and pending words; no m_axis_tvalid SHALL appear until after a new ap_start.
REQ-022 Reset deassertion SHALL take effect on an aclk edge; outputs SHALL remain at reset values until ap_start.

Verification
REQ-023 SHALL cover: ap_start, then 256 bases "ACGT" repeated with tlast on the 256th -> one word with every byte 0xE4, m_axis_tlast=1, ap_done pulse, base_count=256, bad_char=0.
REQ-024 SHALL cover: "GGT" with tlast on T -> m_axis_tdata=0x3A with all upper bits 0, m_axis_tlast=1, tvalid one cycle after the T handshake.
REQ-025 SHALL cover: 512 bases of "T" with m_axis_tready held low for 10 cycles after the first word -> s_axis_tready=0 during the stall, no beat lost, two all-ones words, tlast only on the second.
REQ-026 SHALL cover: input "aNc" + tlast -> data=0x10, bad_char=1 held after done, cleared to 0 by the next ap_start.
REQ-027 SHALL cover: aresetn pulsed low after 100 bases -> all outputs 0 and FSM IDLE immediately; a subsequent ap_start plus 4 bases "CCCC"+tlast -> data=0x55, base_count=4.
REQ-028 SHALL cover: ap_start pulsed during RUN after 10 bases -> base_count continues to 11 and beyond without clearing.
